unpadder: RTL and testbench
===========================

Name: unpadder

Overview:
- Inverse of the zero-padding stage.
- Consumes a word-serial stream of (BITS_IN_NUM + NUM_PADS)-bit frames, least-significant word first, with no backpressure.
- Forwards only BITS_IN_NUM bits per frame: either the low half (strips pad words) or the high half (extracts the upper product half after a double-width multiply).
- Per frame, flags whether any discarded word was nonzero (overflow/invalid pad), so downstream control can detect that a result did not fit in BITS_IN_NUM.

Parameters:
- REGISTER_SIZE, 32, word width of data_in/data_out.
- BITS_IN_NUM, 4096, bits kept per frame; must be a multiple of REGISTER_SIZE.
- NUM_PADS, BITS_IN_NUM, bits discarded per frame; must be a multiple of REGISTER_SIZE.
- KEEP_HIGH, 0, 0 = keep the first KEEP_WORDS words (low half); 1 = keep the last KEEP_WORDS words (high half).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- data_in  input  REGISTER_SIZE  input word, LSW first.
- valid_in  input  1  data_in valid; each high cycle consumes one word.
- data_out  output  REGISTER_SIZE  kept word; 0 when valid_out low.
- valid_out  output  1  data_out valid.
- last_out  output  1  high with the final kept word of a frame.
- frame_done_out  output  1  one-cycle pulse when the final input word of a frame has been consumed.
- drop_nonzero_out  output  1  valid only with frame_done_out; 1 if any discarded word in that frame was nonzero.

Behaviour:
- Constants:
  - TOTAL_WORDS = (BITS_IN_NUM + NUM_PADS)/REGISTER_SIZE.
  - KEEP_WORDS = BITS_IN_NUM/REGISTER_SIZE.
  - DROP_WORDS = NUM_PADS/REGISTER_SIZE.
  - Counter width $clog2(TOTAL_WORDS), minimum 1.
- word_idx counts accepted words 0..TOTAL_WORDS-1.
  - Increments on valid_in.
  - Wraps to 0 after TOTAL_WORDS-1; the next word starts a new frame.
  - There is no frame-start input; frame alignment is set by reset only.
- keep = KEEP_HIGH ? (word_idx >= DROP_WORDS) : (word_idx < KEEP_WORDS).
- All outputs are registered; latency is 1 cycle from valid_in to valid_out/data_out.
  - valid_out <= valid_in && keep.
  - data_out <= (valid_in && keep) ? data_in : 0.
  - last_out <= valid_in && kept index is the final one (KEEP_HIGH ? word_idx==TOTAL_WORDS-1 : word_idx==KEEP_WORDS-1).
- Nonzero tracking:
  - acc_nz is a sticky register.
  - On a valid_in dropped word with data_in != 0, acc_nz is set.
  - On a valid_in with word_idx==TOTAL_WORDS-1: register frame_done_out<=1 and drop_nonzero_out <= acc_nz | (dropped && data_in!=0), then clear acc_nz in the same cycle.
  - Otherwise frame_done_out<=0 and drop_nonzero_out<=0.
- Gaps: valid_in may drop low mid-frame for any number of cycles. Counter and acc_nz hold; all output strobes are 0.
- Back-to-back frames at full rate: frame_done_out of frame k and the first kept word of frame k+1 are not mutually exclusive. With KEEP_HIGH=1, last_out and frame_done_out coincide.
- NUM_PADS=0: nothing is dropped, every word passes, drop_nonzero_out is always 0 at frame end.
- Reset, including mid-frame: word_idx=0, acc_nz=0, and data_out, valid_out, last_out, frame_done_out, drop_nonzero_out all 0 on the next edge. The partial frame is abandoned.
- Elaboration-time assertion fails if BITS_IN_NUM or NUM_PADS is not a multiple of REGISTER_SIZE, or if BITS_IN_NUM is 0.

Decomposition:
- Shared package holds the default widths (REGISTER_SIZE, BITS_IN_NUM) already common to padder/unpadder, plus a word_t typedef.
- The word index reuses the existing evt_counter (MAX_COUNT=TOTAL_WORDS, COUNT_START=0, evt_in=valid_in).
- Keep/drop decode, nonzero accumulation and output registers stay in unpadder; no other sub-module.

Test Plan:
- Use REGISTER_SIZE=32, BITS_IN_NUM=128, NUM_PADS=128 (8 words in, 4 kept) for all scenarios.
- KEEP_HIGH=0; feed 1,2,3,4,0,0,0,0 at full rate -> data_out 1,2,3,4 on cycles 1-4, last_out with 4, frame_done_out on cycle 8 with drop_nonzero_out=0.
- KEEP_HIGH=1; feed 1..8 -> data_out 5,6,7,8, last_out with 8 coincident with frame_done_out, drop_nonzero_out=1.
- KEEP_HIGH=0; two back-to-back frames, the second with word 6 = 0xDEADBEEF -> frame 1 drop flag 0, frame 2 drop flag 1. Confirms acc_nz clears between frames.
- Random valid_in gaps (~50% duty) over 3 frames -> identical data_out sequence to the gap-free case; no strobes during gaps.
- Reset asserted after word 3 of a frame, then a fresh 8-word frame -> all outputs 0 the cycle after reset; the new frame outputs its words 0-3 with correct last_out. No stale nonzero flag.
- NUM_PADS=0 instance -> all 4 words pass; frame_done_out every 4 words with drop_nonzero_out=0.

Source files
------------

// File: rtl/unpadder_pkg.sv
// Shared defaults for the pad/unpad stages.
// Word type and counter width helper.
package unpadder_pkg;

  localparam int DEF_REGISTER_SIZE = 32;
  localparam int DEF_BITS_IN_NUM   = 4096;

  typedef logic [DEF_REGISTER_SIZE-1:0] word_t;

  // Counter width for n states, never below 1 bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/unpadder_evt_counter.sv
// evt_counter: modulo-MAX_COUNT event counter.
// Ports: clk_in, rst_in, evt_in -> count_out, at_max_out.
module evt_counter
  import unpadder_pkg::*;
#(
  parameter int MAX_COUNT   = 8,
  parameter int COUNT_START = 0,
  parameter int W           = cnt_w(MAX_COUNT)
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         evt_in,
  output logic [W-1:0] count_out,
  output logic         at_max_out
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_next;

  assign at_max_out = (r_count == W'(MAX_COUNT - 1));
  assign w_next     = at_max_out ? W'(COUNT_START)
                                 : r_count + W'(1);
  assign count_out  = r_count;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_count <= W'(COUNT_START);
    end else if (evt_in) begin
      r_count <= w_next;
    end
  end

endmodule

// File: rtl/unpadder.sv
// unpadder: keeps BITS_IN_NUM bits of each padded frame.
// Ports: data_in/valid_in -> data_out/valid_out/last_out, frame flags.
module unpadder
  import unpadder_pkg::*;
#(
  parameter int REGISTER_SIZE = DEF_REGISTER_SIZE,
  parameter int BITS_IN_NUM   = DEF_BITS_IN_NUM,
  parameter int NUM_PADS      = BITS_IN_NUM,
  parameter int KEEP_HIGH     = 0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] data_in,
  input  logic                     valid_in,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     valid_out,
  output logic                     last_out,
  output logic                     frame_done_out,
  output logic                     drop_nonzero_out
);

  localparam int TOTAL_WORDS =
    (BITS_IN_NUM + NUM_PADS) / REGISTER_SIZE;
  localparam int KEEP_WORDS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int DROP_WORDS = NUM_PADS / REGISTER_SIZE;
  localparam int CW         = cnt_w(TOTAL_WORDS);

  if ((BITS_IN_NUM % REGISTER_SIZE) != 0 ||
      (NUM_PADS % REGISTER_SIZE) != 0 ||
      BITS_IN_NUM == 0) begin : g_bad_cfg
    $error("unpadder: bad BITS_IN_NUM/NUM_PADS");
  end

  logic [CW-1:0] w_idx;
  logic          w_at_max;
  logic          w_keep;
  logic          w_last_idx;
  logic          w_drop_nz;
  logic          w_take;

  logic [REGISTER_SIZE-1:0] r_data;
  logic                     r_valid;
  logic                     r_last;
  logic                     r_fd;
  logic                     r_nz;
  logic                     r_acc;

  evt_counter #(
    .MAX_COUNT   (TOTAL_WORDS),
    .COUNT_START (0),
    .W           (CW)
  ) u_idx (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .evt_in     (valid_in),
    .count_out  (w_idx),
    .at_max_out (w_at_max)
  );

  // Low mode keeps the leading words, high mode the trailing ones.
  assign w_keep = (KEEP_HIGH != 0)
                ? (int'(w_idx) >= DROP_WORDS)
                : (int'(w_idx) <  KEEP_WORDS);

  assign w_last_idx = (KEEP_HIGH != 0)
                    ? w_at_max
                    : (int'(w_idx) == KEEP_WORDS - 1);

  assign w_drop_nz = !w_keep && (data_in != '0);
  assign w_take    = valid_in && w_keep;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_fd    <= 1'b0;
      r_nz    <= 1'b0;
      r_acc   <= 1'b0;
    end else begin
      r_valid <= w_take;
      r_data  <= w_take ? data_in : '0;
      r_last  <= w_take && w_last_idx;
      if (valid_in && w_at_max) begin
        // Frame end: report including this word, then restart.
        r_fd  <= 1'b1;
        r_nz  <= r_acc | w_drop_nz;
        r_acc <= 1'b0;
      end else begin
        r_fd <= 1'b0;
        r_nz <= 1'b0;
        if (valid_in && w_drop_nz) begin
          r_acc <= 1'b1;
        end
      end
    end
  end

  assign data_out         = r_data;
  assign valid_out        = r_valid;
  assign last_out         = r_last;
  assign frame_done_out   = r_fd;
  assign drop_nonzero_out = r_nz;

endmodule

// File: tb/tb_unpadder.sv
// Bench for unpadder: low, high and no-pad instances in parallel.
// Frame-buffer reference model; one task per scenario.
module tb_unpadder;

  logic        clk = 1'b0;
  logic        rst;
  logic        vin;
  logic [31:0] din;

  logic [31:0] o_d [3];
  logic        o_v [3];
  logic        o_l [3];
  logic        o_f [3];
  logic        o_n [3];

  always #5 clk = ~clk;

  unpadder #(
    .REGISTER_SIZE (32),
    .BITS_IN_NUM   (128),
    .NUM_PADS      (128),
    .KEEP_HIGH     (0)
  ) u_lo (
    .clk_in           (clk),
    .rst_in           (rst),
    .data_in          (din),
    .valid_in         (vin),
    .data_out         (o_d[0]),
    .valid_out        (o_v[0]),
    .last_out         (o_l[0]),
    .frame_done_out   (o_f[0]),
    .drop_nonzero_out (o_n[0])
  );

  unpadder #(
    .REGISTER_SIZE (32),
    .BITS_IN_NUM   (128),
    .NUM_PADS      (128),
    .KEEP_HIGH     (1)
  ) u_hi (
    .clk_in           (clk),
    .rst_in           (rst),
    .data_in          (din),
    .valid_in         (vin),
    .data_out         (o_d[1]),
    .valid_out        (o_v[1]),
    .last_out         (o_l[1]),
    .frame_done_out   (o_f[1]),
    .drop_nonzero_out (o_n[1])
  );

  unpadder #(
    .REGISTER_SIZE (32),
    .BITS_IN_NUM   (128),
    .NUM_PADS      (0),
    .KEEP_HIGH     (0)
  ) u_np (
    .clk_in           (clk),
    .rst_in           (rst),
    .data_in          (din),
    .valid_in         (vin),
    .data_out         (o_d[2]),
    .valid_out        (o_v[2]),
    .last_out         (o_l[2]),
    .frame_done_out   (o_f[2]),
    .drop_nonzero_out (o_n[2])
  );

  int nchk  = 0;
  int npass = 0;

  int tw [3];
  int kw [3];
  int kh [3];

  logic [31:0] fr [3][$];
  int          nkept [3];
  logic [31:0] e_d [3];
  bit          e_v [3];
  bit          e_l [3];
  bit          e_f [3];
  bit          e_n [3];

  function automatic bit kept(input int k, input int p);
    if (kh[k] != 0) return p >= tw[k] - kw[k];
    return p < kw[k];
  endfunction

  function automatic void model(input bit r, input bit v,
                                input logic [31:0] d);
    for (int k = 0; k < 3; k++) begin
      e_d[k] = '0; e_v[k] = 0; e_l[k] = 0;
      e_f[k] = 0;  e_n[k] = 0;
      if (r) begin
        fr[k].delete();
        nkept[k] = 0;
      end else if (v) begin
        if (kept(k, fr[k].size())) begin
          e_v[k] = 1;
          e_d[k] = d;
          nkept[k]++;
          e_l[k] = (nkept[k] == kw[k]);
        end
        fr[k].push_back(d);
        if (fr[k].size() == tw[k]) begin
          e_f[k] = 1;
          for (int i = 0; i < tw[k]; i++)
            if (!kept(k, i) && fr[k][i] != 0) e_n[k] = 1;
          fr[k].delete();
          nkept[k] = 0;
        end
      end
    end
  endfunction

  task automatic cyc(input bit r, input bit v,
                     input logic [31:0] d);
    rst = r; vin = v; din = d;
    @(posedge clk);
    model(r, v, d);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0);
    cyc(1, 1, 32'h55);
    for (int k = 0; k < 3; k++) begin
      nchk++;
      if ({o_v[k], o_l[k], o_f[k], o_n[k], o_d[k]} !== 36'h0)
        $display("FAIL reset k=%0d got %h exp 0", k,
                 {o_v[k], o_l[k], o_f[k], o_n[k], o_d[k]});
      else npass++;
    end
  endtask

  task automatic test_keep_low();
    logic [31:0] w [8] = '{1, 2, 3, 4, 0, 0, 0, 0};
    for (int s = 0; s < 8; s++) begin
      cyc(0, 1, w[s]);
      for (int k = 0; k < 3; k++) begin
        nchk++;
        if ({o_v[k], o_l[k], o_f[k], o_n[k], o_d[k]} !==
            {e_v[k], e_l[k], e_f[k], e_n[k], e_d[k]})
          $display("FAIL keep_low k=%0d s=%0d got %h exp %h", k, s,
                   {o_v[k], o_l[k], o_f[k], o_n[k], o_d[k]},
                   {e_v[k], e_l[k], e_f[k], e_n[k], e_d[k]});
        else npass++;
      end
      if (s == 3) begin
        nchk++;
        if ({o_l[0], o_d[0]} !== {1'b1, 32'd4})
          $display("FAIL keep_low_last got %h exp 100000004",
                   {o_l[0], o_d[0]});
        else npass++;
      end
      if (s == 7) begin
        nchk++;
        if ({o_f[0], o_n[0], o_v[0]} !== 3'b100)
          $display("FAIL keep_low_done got %b exp 100",
                   {o_f[0], o_n[0], o_v[0]});
        else npass++;
      end
    end
  endtask

  task automatic test_keep_high();
    for (int s = 0; s < 8; s++) begin
      cyc(0, 1, 32'(s + 1));
      for (int k = 0; k < 3; k++) begin
        nchk++;
        if ({o_v[k], o_l[k], o_f[k], o_n[k], o_d[k]} !==
            {e_v[k], e_l[k], e_f[k], e_n[k], e_d[k]})
          $display("FAIL keep_high k=%0d s=%0d got %h exp %h", k, s,
                   {o_v[k], o_l[k], o_f[k], o_n[k], o_d[k]},
                   {e_v[k], e_l[k], e_f[k], e_n[k], e_d[k]});
        else npass++;
      end
      if (s == 7) begin
        nchk++;
        if ({o_v[1], o_l[1], o_f[1], o_n[1], o_d[1]} !==
            {4'b1111, 32'd8})
          $display("FAIL keep_high_end got %h exp f00000008",
                   {o_v[1], o_l[1], o_f[1], o_n[1], o_d[1]});
        else npass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    for (int s = 0; s < 16; s++) begin
      w = (s % 8 < 4) ? $urandom : 32'h0;
      if (s == 14) w = 32'hDEADBEEF;
      cyc(0, 1, w);
      for (int k = 0; k < 3; k++) begin
        nchk++;
        if ({o_v[k], o_l[k], o_f[k], o_n[k], o_d[k]} !==
            {e_v[k], e_l[k], e_f[k], e_n[k], e_d[k]})
          $display("FAIL b2b k=%0d s=%0d got %h exp %h", k, s,
                   {o_v[k], o_l[k], o_f[k], o_n[k], o_d[k]},
                   {e_v[k], e_l[k], e_f[k], e_n[k], e_d[k]});
        else npass++;
      end
      if (s == 7 || s == 15) begin
        nchk++;
        if ({o_f[0], o_n[0]} !== {1'b1, s == 15})
          $display("FAIL b2b_flag s=%0d got %b exp %b", s,
                   {o_f[0], o_n[0]}, {1'b1, s == 15});
        else npass++;
      end
    end
  endtask

  task automatic test_random_gaps();
    int          acc = 0;
    bit          v;
    logic [31:0] w;
    while (acc < 24) begin
      v = ($urandom_range(0, 1) == 1);
      w = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      cyc(0, v, w);
      if (v) acc++;
      for (int k = 0; k < 3; k++) begin
        nchk++;
        if ({o_v[k], o_l[k], o_f[k], o_n[k], o_d[k]} !==
            {e_v[k], e_l[k], e_f[k], e_n[k], e_d[k]})
          $display("FAIL gaps k=%0d n=%0d got %h exp %h", k, acc,
                   {o_v[k], o_l[k], o_f[k], o_n[k], o_d[k]},
                   {e_v[k], e_l[k], e_f[k], e_n[k], e_d[k]});
        else npass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w [8] = '{11, 12, 13, 14, 0, 0, 0, 0};
    for (int s = 0; s < 3; s++) cyc(0, 1, 32'hA0 + 32'(s));
    cyc(1, 1, 32'hFFFF_FFFF);
    for (int k = 0; k < 3; k++) begin
      nchk++;
      if ({o_v[k], o_l[k], o_f[k], o_n[k], o_d[k]} !== 36'h0)
        $display("FAIL reset_mid k=%0d got %h exp 0", k,
                 {o_v[k], o_l[k], o_f[k], o_n[k], o_d[k]});
      else npass++;
    end
    for (int s = 0; s < 8; s++) begin
      cyc(0, 1, w[s]);
      for (int k = 0; k < 3; k++) begin
        nchk++;
        if ({o_v[k], o_l[k], o_f[k], o_n[k], o_d[k]} !==
            {e_v[k], e_l[k], e_f[k], e_n[k], e_d[k]})
          $display("FAIL reset_mid k=%0d s=%0d got %h exp %h", k, s,
                   {o_v[k], o_l[k], o_f[k], o_n[k], o_d[k]},
                   {e_v[k], e_l[k], e_f[k], e_n[k], e_d[k]});
        else npass++;
      end
    end
    nchk++;
    if ({o_f[0], o_n[0]} !== 2'b10)
      $display("FAIL reset_mid_stale got %b exp 10",
               {o_f[0], o_n[0]});
    else npass++;
  endtask

  initial begin
    tw[0] = 8; kw[0] = 4; kh[0] = 0;
    tw[1] = 8; kw[1] = 4; kh[1] = 1;
    tw[2] = 4; kw[2] = 4; kh[2] = 0;
    rst = 1'b1; vin = 1'b0; din = '0;
    test_reset();
    test_keep_low();
    test_keep_high();
    test_back_to_back();
    test_random_gaps();
    test_reset_mid();
    cyc(0, 0, 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
